// File: rtl/reg_file_64_if.sv
// Bus bundle for the 32-entry register file: one write port, two combinational read ports
// and the registered discarded-write flag.
interface reg_file_64_if #(
  parameter int N = 64
);
  logic         RegWrite;
  logic [4:0]   WriteReg;
  logic [N-1:0] WriteData;
  logic [4:0]   ReadReg1;
  logic [4:0]   ReadReg2;
  logic [N-1:0] ReadData1;
  logic [N-1:0] ReadData2;
  logic         WriteIgnored;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WriteIgnored
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteIgnored
  );
endinterface

// File: rtl/reg_file_64.sv
// 32 x N register file with a hard-wired zero register, same-cycle write-to-read bypass
// and a one-cycle flag for writes aimed at the zero register.
module reg_file_64 #(
  parameter int N      = 64,
  parameter int ZR_IDX = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_64_if.slave  bus
);

  localparam logic [4:0] ZR = ZR_IDX[4:0];

  logic [N-1:0] regs_q [32];
  logic [N-1:0] regs_d [32];
  logic         write_ignored_q;
  logic         write_ignored_d;
  logic         wr_en;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;

  always_comb begin
    // NOTE: every signal gets a default before any condition, so no path leaves it
    // unassigned and no latch is inferred.
    regs_d          = regs_q;
    wr_en           = bus.RegWrite && (bus.WriteReg != ZR);
    write_ignored_d = bus.RegWrite && (bus.WriteReg == ZR);
    if (wr_en) begin
      regs_d[bus.WriteReg] = bus.WriteData;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: <= so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the storage array is reset on purpose: unwritten registers must read as zero.
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      write_ignored_q <= 1'b0;
    end else begin
      regs_q          <= regs_d;
      write_ignored_q <= write_ignored_d;
    end
  end

  // Bypass is gated by rst_n because a write presented during reset is discarded.
  always_comb begin
    rd1 = regs_q[bus.ReadReg1];
    if (rst_n && wr_en && (bus.WriteReg == bus.ReadReg1)) begin
      rd1 = bus.WriteData;
    end
    if (bus.ReadReg1 == ZR) begin
      rd1 = '0;
    end

    rd2 = regs_q[bus.ReadReg2];
    if (rst_n && wr_en && (bus.WriteReg == bus.ReadReg2)) begin
      rd2 = bus.WriteData;
    end
    if (bus.ReadReg2 == ZR) begin
      rd2 = '0;
    end
  end

  assign bus.ReadData1    = rd1;
  assign bus.ReadData2    = rd2;
  assign bus.WriteIgnored = write_ignored_q;

endmodule

// File: tb/tb_reg_file_64.sv
// Self-checking bench for reg_file_64: constant vector table, reset sequences and a
// random stream against a reference array; WriteIgnored expectations flow through a queue.
module tb_reg_file_64;

  localparam int         N  = 64;
  localparam logic [4:0] ZR = 5'd31;

  logic clk;
  logic rst_n;

  reg_file_64_if #(.N(N)) bus ();

  reg_file_64 #(.N(N), .ZR_IDX(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         we;
    logic [4:0]   wr;
    logic [N-1:0] wd;
    logic [4:0]   r1;
    logic [4:0]   r2;
    logic [N-1:0] e1;
    logic [N-1:0] e2;
    logic         e_ign;
  } vec_t;

  int           total;
  int           bad;
  logic [N-1:0] model [32];
  logic         ign_q [$];
  vec_t         vecs [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_read(input logic [4:0] idx, input logic rn,
                                            input logic we, input logic [4:0] wr,
                                            input logic [N-1:0] wd);
    if (idx == ZR) return '0;
    if (rn && we && (wr != ZR) && (wr == idx)) return wd;
    return model[idx];
  endfunction

  // One clock cycle: check last edge's flag, drive, sample reads #1 later, update model.
  task automatic cycle(input logic rn, input logic we, input logic [4:0] wr,
                       input logic [N-1:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic exp_ign, output logic [N-1:0] got1,
                       output logic [N-1:0] got2);
    @(negedge clk);
    if (ign_q.size() > 0) begin
      check("write_ignored", N'(bus.WriteIgnored), N'(ign_q.pop_front()));
    end
    rst_n        = rn;
    bus.RegWrite = we;
    bus.WriteReg = wr;
    bus.WriteData = wd;
    bus.ReadReg1 = r1;
    bus.ReadReg2 = r2;
    #1;
    got1 = bus.ReadData1;
    got2 = bus.ReadData2;
    ign_q.push_back(exp_ign);
    if (!rn) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && (wr != ZR)) begin
      model[wr] = wd;
    end
  endtask

  initial begin
    logic [N-1:0] g1, g2;
    logic [N-1:0] e1, e2;
    logic         rn, we;
    logic [4:0]   wr, r1, r2;
    logic [N-1:0] wd;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.WriteReg  = '0;
    bus.WriteData = '0;
    bus.ReadReg1  = '0;
    bus.ReadReg2  = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // First reset edge: storage undefined until it, so no read check here.
    cycle(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd1, 1'b0, g1, g2);

    // Reset held: every index reads 0, and writes presented now must not bypass.
    for (int i = 0; i < 16; i++) begin
      r1 = 5'(2 * i);
      r2 = 5'(2 * i + 1);
      cycle(1'b0, 1'b1, r1, 64'hCAFE_0000_0000_0001, r1, r2, 1'b0, g1, g2);
      check("reset_read1", g1, '0);
      check("reset_read2", g2, '0);
    end

    // Directed vector table, every expectation a constant.
    vecs.push_back('{1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 5'd0,  5'd0,  64'h0, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 5'd0,  64'h0,                   5'd5,  5'd4,  64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 5'd0,  64'h0,                   5'd6,  5'd5,  64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0});
    vecs.push_back('{1'b1, 5'd9,  64'h1,                   5'd9,  5'd9,  64'h1, 64'h1, 1'b0});
    vecs.push_back('{1'b0, 5'd0,  64'h0,                   5'd9,  5'd31, 64'h1, 64'h0, 1'b0});
    vecs.push_back('{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 64'h0, 64'h0, 1'b1});
    vecs.push_back('{1'b0, 5'd0,  64'h0,                   5'd31, 5'd5,  64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0});
    vecs.push_back('{1'b1, 5'd0,  64'h8000_0000_0000_0001, 5'd0,  5'd1,  64'h8000_0000_0000_0001, 64'h0, 1'b0});
    vecs.push_back('{1'b1, 5'd30, 64'hA5A5_5A5A_A5A5_5A5A, 5'd30, 5'd0,  64'hA5A5_5A5A_A5A5_5A5A, 64'h8000_0000_0000_0001, 1'b0});
    vecs.push_back('{1'b1, 5'd31, 64'h1234,                5'd30, 5'd31, 64'hA5A5_5A5A_A5A5_5A5A, 64'h0, 1'b1});
    vecs.push_back('{1'b1, 5'd31, 64'h5678,                5'd9,  5'd0,  64'h1, 64'h8000_0000_0000_0001, 1'b1});
    vecs.push_back('{1'b1, 5'd5,  64'h0123,                5'd5,  5'd5,  64'h0123, 64'h0123, 1'b0});
    vecs.push_back('{1'b0, 5'd5,  64'hFFFF,                5'd5,  5'd4,  64'h0123, 64'h0, 1'b0});
    foreach (vecs[k]) begin
      cycle(1'b1, vecs[k].we, vecs[k].wr, vecs[k].wd, vecs[k].r1, vecs[k].r2,
            vecs[k].e_ign, g1, g2);
      check($sformatf("vec%0d_rd1", k), g1, vecs[k].e1);
      check($sformatf("vec%0d_rd2", k), g2, vecs[k].e2);
    end

    // Fill X0..X30 with their index, bypass visible in the writing cycle.
    for (int i = 0; i < 31; i++) begin
      cycle(1'b1, 1'b1, 5'(i), N'(i), 5'(i), 5'd31, 1'b0, g1, g2);
      check("fill_bypass", g1, N'(i));
    end
    // Reset with a write pending: reads show storage (no bypass) until the edge.
    cycle(1'b0, 1'b1, 5'd3, 64'h77, 5'd3, 5'd30, 1'b0, g1, g2);
    check("rst_nobypass_x3", g1, 64'd3);
    check("rst_storage_x30", g2, 64'd30);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 5'd0, '0, 5'(2 * i), 5'(2 * i + 1), 1'b0, g1, g2);
      check("post_rst_rd1", g1, '0);
      check("post_rst_rd2", g2, '0);
    end
    // Write in the first cycle after a reset edge is accepted immediately.
    cycle(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, g1, g2);
    cycle(1'b1, 1'b1, 5'd12, 64'h55, 5'd0, 5'd0, 1'b0, g1, g2);
    cycle(1'b1, 1'b0, 5'd0, '0, 5'd12, 5'd11, 1'b0, g1, g2);
    check("first_cycle_write", g1, 64'h55);
    check("first_cycle_other", g2, 64'h0);

    // Random stream against the reference array.
    for (int c = 0; c < 10000; c++) begin
      rn = ($urandom_range(199) != 0);
      we = ($urandom_range(3) != 0);
      wr = ($urandom_range(7) == 0) ? ZR : 5'($urandom_range(31));
      wd = {$urandom(), $urandom()};
      r1 = ($urandom_range(3) == 0) ? wr : 5'($urandom_range(31));
      r2 = ($urandom_range(3) == 0) ? r1 : 5'($urandom_range(31));
      e1 = exp_read(r1, rn, we, wr, wd);
      e2 = exp_read(r2, rn, we, wr, wd);
      cycle(rn, we, wr, wd, r1, r2, rn && we && (wr == ZR), g1, g2);
      check("rand_rd1", g1, e1);
      check("rand_rd2", g2, e2);
    end

    // Drain the last pending flag expectation.
    @(negedge clk);
    while (ign_q.size() > 0) begin
      check("write_ignored", N'(bus.WriteIgnored), N'(ign_q.pop_front()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
